// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Brings up the clock-manager PLL from the always-present 100 MHz reference.
// It pulses the PLL reset and waits for lock, retrying on timeout. Once lock
// has been continuously stable it releases the SDR datapath domain resets one
// at a time. Loss of lock drops every domain back into reset. A FAIL state is
// latched after too many timeout retries.
//
// Ports:
//   i_clk_100m_in  reference clock, the only clock in this block
//   i_rst_n        asynchronous active-low reset
//   i_pll_locked   raw asynchronous PLL lock (2-flop synchronised inside)
//   i_restart_req  single-cycle request to re-run the whole sequence
//   o_pll_rst_n    PLL reset, active low
//   o_dom_rst_n    domain resets, active low:
//                  [0] adc105 [1] ddc600 [2] fft1200 [3] eth125 [4] eth250
//   o_sys_ready    high while running with all domains released
//   o_lock_lost    sticky flag: lock dropped during RELEASE or RUN
//   o_fail         high in FAIL
//   o_retry_cnt    lock-timeout retries used in the current bring-up
//   o_state        PLL_RST=0 WAIT_LOCK=1 STABLE=2 RELEASE=3 RUN=4 FAIL=5
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES      = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       i_clk_100m_in,
  input  logic       i_rst_n,
  input  logic       i_pll_locked,
  input  logic       i_restart_req,
  output logic       o_pll_rst_n,
  output logic [4:0] o_dom_rst_n,
  output logic       o_sys_ready,
  output logic       o_lock_lost,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  // One shared cycle counter serves every timed state, so it is sized for the
  // longest interval.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES : STAGGER_CYCLES;
  localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_idx;
  logic [3:0]  r_retry;
  logic [4:0]  r_dom;
  logic        r_pll_rst_n;
  logic        r_sys_ready;
  logic        r_lock_lost;
  logic        r_fail;
  logic        r_lock_meta;
  logic        r_lock_sync;

  state_t      w_state_nx;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]  w_idx_nx;
  logic [3:0]  w_retry_nx;
  logic [4:0]  w_dom_nx;
  logic        w_lost_nx;
  logic        w_lock_s;

  // Saturating counter step; the counter must never wrap back to zero.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  assign w_lock_s = r_lock_sync;

  // Two-flop synchroniser for the asynchronous PLL lock input.
  always_ff @(posedge i_clk_100m_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Next-state, counter, retry and release-mask logic. Restart beats lock
  // loss, lock loss beats timeout, and timeout beats normal counting.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_retry_nx = r_retry;
    w_dom_nx   = r_dom;
    w_lost_nx  = r_lock_lost;
    if (i_restart_req) begin
      w_state_nx = ST_PLL_RST;
      w_cnt_nx   = CNT_ZERO;
      w_idx_nx   = 3'd0;
      w_retry_nx = 4'd0;
      w_dom_nx   = 5'b00000;
      w_lost_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          w_dom_nx = 5'b00000;
          if (r_cnt >= PLL_RST_LAST) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = CNT_ZERO;
          end else begin
            w_cnt_nx = sat_inc(r_cnt);
          end
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nx = ST_STABLE;
            w_cnt_nx   = CNT_ZERO;
          end else if (r_cnt >= TIMEOUT_LAST) begin
            w_cnt_nx = CNT_ZERO;
            if (r_retry >= RETRY_MAX) begin
              w_state_nx = ST_FAIL;
            end else begin
              w_state_nx = ST_PLL_RST;
              w_retry_nx = r_retry + 4'd1;
            end
          end else begin
            w_cnt_nx = sat_inc(r_cnt);
          end
        end
        ST_STABLE: begin
          // A glitch restarts the lock wait without consuming a retry.
          if (!w_lock_s) begin
            w_state_nx = ST_WAIT_LOCK;
            w_cnt_nx   = CNT_ZERO;
          end else if (r_cnt >= STABLE_LAST) begin
            w_state_nx = ST_RELEASE;
            w_cnt_nx   = CNT_ZERO;
            w_idx_nx   = 3'd0;
          end else begin
            w_cnt_nx = sat_inc(r_cnt);
          end
        end
        ST_RELEASE: begin
          if (!w_lock_s) begin
            w_state_nx = ST_PLL_RST;
            w_cnt_nx   = CNT_ZERO;
            w_idx_nx   = 3'd0;
            w_dom_nx   = 5'b00000;
            w_lost_nx  = 1'b1;
          end else if (r_cnt >= STAGGER_LAST) begin
            w_cnt_nx = CNT_ZERO;
            w_dom_nx = r_dom | (5'b00001 << r_idx);
            if (r_idx >= 3'd4) begin
              w_state_nx = ST_RUN;
              w_retry_nx = 4'd0;
            end else begin
              w_idx_nx = r_idx + 3'd1;
            end
          end else begin
            w_cnt_nx = sat_inc(r_cnt);
          end
        end
        ST_RUN: begin
          if (!w_lock_s) begin
            w_state_nx = ST_PLL_RST;
            w_cnt_nx   = CNT_ZERO;
            w_idx_nx   = 3'd0;
            w_dom_nx   = 5'b00000;
            w_lost_nx  = 1'b1;
          end else begin
            w_state_nx = ST_RUN;
          end
        end
        ST_FAIL: begin
          w_dom_nx = 5'b00000;
        end
        default: begin
          w_state_nx = ST_PLL_RST;
          w_cnt_nx   = CNT_ZERO;
          w_idx_nx   = 3'd0;
          w_dom_nx   = 5'b00000;
        end
      endcase
    end
  end

  // State, counters and registered outputs. Outputs are derived from the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge i_clk_100m_in or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= CNT_ZERO;
      r_idx       <= 3'd0;
      r_retry     <= 4'd0;
      r_dom       <= 5'b00000;
      r_pll_rst_n <= 1'b0;
      r_sys_ready <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_idx       <= w_idx_nx;
      r_retry     <= w_retry_nx;
      r_dom       <= w_dom_nx;
      r_pll_rst_n <= (w_state_nx != ST_PLL_RST) && (w_state_nx != ST_FAIL);
      // Rises one cycle after RUN entry, i.e. one cycle after the last domain
      // release, and drops on the same edge that leaves RUN.
      r_sys_ready <= (r_state == ST_RUN) && (w_state_nx == ST_RUN);
      r_lock_lost <= w_lost_nx;
      r_fail      <= (w_state_nx == ST_FAIL);
    end
  end

  assign o_pll_rst_n = r_pll_rst_n;
  assign o_dom_rst_n = r_dom;
  assign o_sys_ready = r_sys_ready;
  assign o_lock_lost = r_lock_lost;
  assign o_fail      = r_fail;
  assign o_retry_cnt = r_retry;
  assign o_state     = r_state;

endmodule
